// File: rtl/pool_1st_max_pkg.sv
// rtl/pool_1st_max_pkg.sv - shared constants and state type for the first-layer max-pooling stage
package pool_1st_max_pkg;

    localparam int CONV1_LANES = 40;
    localparam int CONV1_ROWS  = 40;
    localparam int CONV1_MAPS  = 32;
    localparam int LANE_W      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } state_t;

endpackage

// File: rtl/pool_1st_max_max2_u8.sv
// rtl/pool_1st_max_max2_u8.sv - unsigned 8-bit two-input maximum
// Ports:
//   a, b : unsigned operands
//   y    : larger of a and b
module max2_u8
    import pool_1st_max_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] y
);

    assign y = (a >= b) ? a : b;

endmodule

// File: rtl/pool_1st_max.sv
// rtl/pool_1st_max.sv - 2x2 stride-2 max pooling of first-layer convolution rows
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   sta           : frame start pulse; clears counters, buffer and restarts at EVEN
//   conv_i        : LANES unsigned 8-bit lanes, lane k at [(k+1)*8-1 -: 8]
//   valid_i       : one row beat per cycle when high
//   pool_o        : LANES/2 pooled lanes, held until the next valid_o
//   valid_o       : one-cycle pulse per pooled row
//   row_o, map_o  : pooled-row index within the map, map index
//   map_last_o    : high with valid_o on the last pooled row of a map
//   frame_done_o  : high with the final valid_o of the last map
module pool_1st_max
    import pool_1st_max_pkg::*;
#(
    parameter int LANES = CONV1_LANES,
    parameter int ROWS  = CONV1_ROWS,
    parameter int MAPS  = CONV1_MAPS
)
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sta,
    input  logic [LANES*LANE_W-1:0]   conv_i,
    input  logic                      valid_i,
    output logic [LANES/2*LANE_W-1:0] pool_o,
    output logic                      valid_o,
    output logic [4:0]                row_o,
    output logic [4:0]                map_o,
    output logic                      map_last_o,
    output logic                      frame_done_o
);

    localparam int HL = LANES / 2;
    localparam int RW = $clog2(ROWS);
    localparam int MW = (MAPS > 1) ? $clog2(MAPS) : 1;

    state_t            state_q;
    state_t            state_d;
    logic [RW-1:0]     row_cnt;
    logic [MW-1:0]     map_cnt;
    logic [RW-1:0]     pooled_row;
    logic [LANE_W-1:0] buf_q [HL];
    logic [LANE_W-1:0] h     [HL];
    logic [LANE_W-1:0] v     [HL];
    logic              accept;
    logic              even_beat;
    logic              odd_beat;
    logic              last_row;
    logic              last_map;

    assign last_row   = (row_cnt == RW'(ROWS - 1));
    assign last_map   = (map_cnt == MW'(MAPS - 1));
    assign pooled_row = row_cnt >> 1;

    // Horizontal pair max per row, then vertical max against the buffered even row.
    for (genvar j = 0; j < HL; j++) begin : g_lane
        max2_u8 u_hmax (
            .a (conv_i[(2*j+1)*LANE_W-1 -: LANE_W]),
            .b (conv_i[(2*j+2)*LANE_W-1 -: LANE_W]),
            .y (h[j])
        );
        max2_u8 u_vmax (
            .a (buf_q[j]),
            .b (h[j]),
            .y (v[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sta) begin
            state_d = EVEN;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                EVEN: if (valid_i) state_d = ODD;
                ODD:  if (valid_i) state_d = (last_row && last_map) ? IDLE : EVEN;
                default: state_d = IDLE;
            endcase
        end
    end

    // A beat coinciding with sta belongs to no frame and is dropped.
    always_comb begin
        accept    = valid_i && !sta && (state_q != IDLE);
        even_beat = accept && (state_q == EVEN);
        odd_beat  = accept && (state_q == ODD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt <= '0;
            map_cnt <= '0;
        end else if (sta) begin
            row_cnt <= '0;
            map_cnt <= '0;
        end else if (accept) begin
            if (last_row) begin
                row_cnt <= '0;
                map_cnt <= last_map ? '0 : map_cnt + 1'b1;
            end else begin
                row_cnt <= row_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < HL; j++) buf_q[j] <= '0;
        end else if (sta) begin
            for (int j = 0; j < HL; j++) buf_q[j] <= '0;
        end else if (even_beat) begin
            for (int j = 0; j < HL; j++) buf_q[j] <= h[j];
        end
    end

    // The odd row of a pair always lands on an odd row count, so last_row there
    // marks the last pooled row of the map.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pool_o       <= '0;
            valid_o      <= 1'b0;
            row_o        <= '0;
            map_o        <= '0;
            map_last_o   <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            valid_o      <= odd_beat;
            map_last_o   <= odd_beat && last_row;
            frame_done_o <= odd_beat && last_row && last_map;
            if (odd_beat) begin
                for (int j = 0; j < HL; j++) pool_o[j*LANE_W +: LANE_W] <= v[j];
                row_o <= 5'(pooled_row);
                map_o <= 5'(map_cnt);
            end
        end
    end

endmodule

// File: tb/tb_pool_1st_max.sv
// tb/tb_pool_1st_max.sv - directed self-checking bench for pool_1st_max
module tb_pool_1st_max;

    localparam int L  = 40;
    localparam int R  = 40;
    localparam int M  = 32;

    logic           clk;
    logic           rst_n;
    logic           sta;
    logic [L*8-1:0] conv_i;
    logic           valid_i;
    logic [L*4-1:0] pool_o;
    logic           valid_o;
    logic [4:0]     row_o;
    logic [4:0]     map_o;
    logic           map_last_o;
    logic           frame_done_o;

    int total = 0;
    int bad   = 0;
    int vcnt, mlcnt, fdcnt, fd_at;
    logic [L*8-1:0] beat_a;
    logic [L*8-1:0] beat_b;

    pool_1st_max dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sta          (sta),
        .conv_i       (conv_i),
        .valid_i      (valid_i),
        .pool_o       (pool_o),
        .valid_o      (valid_o),
        .row_o        (row_o),
        .map_o        (map_o),
        .map_last_o   (map_last_o),
        .frame_done_o (frame_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [L*4-1:0] obs, input logic [L*4-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [L*8-1:0] fill(input logic [7:0] b);
        return {L{b}};
    endfunction

    function automatic logic [L*4-1:0] fillp(input logic [7:0] b);
        return {(L/2){b}};
    endfunction

    function automatic logic [L*8-1:0] sbeat(input int i);
        logic [L*8-1:0] r;
        for (int k = 0; k < L; k++) r[k*8 +: 8] = 8'(i*13 + k*7 + 5);
        return r;
    endfunction

    // Reference: each output lane is the largest of the four inputs of its 2x2 window.
    function automatic logic [L*4-1:0] pool_ref(input logic [L*8-1:0] a, input logic [L*8-1:0] b);
        logic [L*4-1:0] r;
        logic [7:0] m;
        logic [7:0] w [4];
        for (int j = 0; j < L/2; j++) begin
            w[0] = a[(2*j)*8 +: 8];
            w[1] = a[(2*j+1)*8 +: 8];
            w[2] = b[(2*j)*8 +: 8];
            w[3] = b[(2*j+1)*8 +: 8];
            m = 8'd0;
            for (int q = 0; q < 4; q++) if (w[q] > m) m = w[q];
            r[j*8 +: 8] = m;
        end
        return r;
    endfunction

    initial begin
        rst_n = 1'b0; sta = 1'b0; valid_i = 1'b0; conv_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(valid_o), 0);
        chkw("rst_pool", pool_o, '0);
        chk("rst_row", 32'(row_o), 0);
        chk("rst_map", 32'(map_o), 0);
        chk("rst_maplast", 32'(map_last_o), 0);
        chk("rst_fdone", 32'(frame_done_o), 0);
        @(negedge clk) rst_n = 1'b1;

        // basic pair
        @(negedge clk) sta = 1'b1;
        @(negedge clk) sta = 1'b0; valid_i = 1'b1; conv_i = fill(8'h10);
        @(negedge clk);
        chk("pair_even_novalid", 32'(valid_o), 0);
        conv_i = fill(8'h20);
        @(negedge clk);
        valid_i = 1'b0;
        chk("pair_valid", 32'(valid_o), 1);
        chkw("pair_pool", pool_o, fillp(8'h20));
        chk("pair_row", 32'(row_o), 0);
        chk("pair_map", 32'(map_o), 0);
        chk("pair_maplast", 32'(map_last_o), 0);
        @(negedge clk);
        chk("pair_pulse", 32'(valid_o), 0);
        chkw("pair_hold", pool_o, fillp(8'h20));

        // lane pattern: A lane k = k, B lane k = 39-k
        for (int k = 0; k < L; k++) begin
            beat_a[k*8 +: 8] = 8'(k);
            beat_b[k*8 +: 8] = 8'(39 - k);
        end
        valid_i = 1'b1; conv_i = beat_a;
        @(negedge clk) conv_i = beat_b;
        @(negedge clk) valid_i = 1'b0;
        chk("lane_valid", 32'(valid_o), 1);
        chk("lane_row", 32'(row_o), 1);
        chk("lane0", 32'(pool_o[7:0]), 39);
        chk("lane10", 32'(pool_o[87:80]), 21);
        chk("lane19", 32'(pool_o[159:152]), 39);
        chkw("lane_all", pool_o, pool_ref(beat_a, beat_b));

        // one full map back-to-back
        @(negedge clk) sta = 1'b1;
        @(negedge clk) sta = 1'b0;
        for (int i = 0; i < R; i++) begin
            valid_i = 1'b1; conv_i = sbeat(i);
            @(negedge clk);
            if (i % 2 == 0) begin
                chk("map_even_novalid", 32'(valid_o), 0);
            end else begin
                chk("map_valid", 32'(valid_o), 1);
                chk("map_row", 32'(row_o), 32'(i / 2));
                chk("map_map", 32'(map_o), 0);
                chk("map_maplast", 32'(map_last_o), (i == R - 1) ? 1 : 0);
                chk("map_fdone", 32'(frame_done_o), 0);
                chkw("map_pool", pool_o, pool_ref(sbeat(i - 1), sbeat(i)));
            end
        end
        conv_i = fill(8'h05);
        @(negedge clk) conv_i = fill(8'h06);
        @(negedge clk) valid_i = 1'b0;
        chk("map1_valid", 32'(valid_o), 1);
        chk("map1_row", 32'(row_o), 0);
        chk("map1_map", 32'(map_o), 1);
        chkw("map1_pool", pool_o, fillp(8'h06));

        // whole frame
        vcnt = 0; mlcnt = 0; fdcnt = 0; fd_at = 0;
        @(negedge clk) sta = 1'b1;
        @(negedge clk) sta = 1'b0;
        for (int i = 0; i < R * M; i++) begin
            valid_i = 1'b1; conv_i = fill(8'(i));
            @(negedge clk);
            if (valid_o) begin
                vcnt++;
                if (map_last_o) mlcnt++;
            end
            if (frame_done_o) begin
                fdcnt++;
                fd_at = vcnt;
            end
        end
        valid_i = 1'b0;
        chk("frame_valids", 32'(vcnt), 640);
        chk("frame_maplasts", 32'(mlcnt), 32);
        chk("frame_fdone_cnt", 32'(fdcnt), 1);
        chk("frame_fdone_at", 32'(fd_at), 640);
        chk("frame_last_row", 32'(row_o), 19);
        chk("frame_last_map", 32'(map_o), 31);
        chk("frame_last_maplast", 32'(map_last_o), 1);
        chkw("frame_last_pool", pool_o, fillp(8'hff));
        @(negedge clk);
        chk("frame_fdone_pulse", 32'(frame_done_o), 0);
        vcnt = 0;
        valid_i = 1'b1; conv_i = fill(8'h44);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (valid_o) vcnt++;
        end
        valid_i = 1'b0;
        @(negedge clk);
        if (valid_o) vcnt++;
        chk("idle_no_output", 32'(vcnt), 0);
        chkw("idle_pool_hold", pool_o, fillp(8'hff));

        // sta after the EVEN beat discards the partial pair
        sta = 1'b1;
        @(negedge clk) sta = 1'b0; valid_i = 1'b1; conv_i = fill(8'h77);
        @(negedge clk) valid_i = 1'b0; sta = 1'b1;
        @(negedge clk) sta = 1'b0;
        chk("restart_novalid", 32'(valid_o), 0);
        valid_i = 1'b1; conv_i = fill(8'h03);
        @(negedge clk) conv_i = fill(8'h04);
        chk("restart_partial_dropped", 32'(valid_o), 0);
        @(negedge clk) valid_i = 1'b0;
        chk("restart_valid", 32'(valid_o), 1);
        chk("restart_row", 32'(row_o), 0);
        chk("restart_map", 32'(map_o), 0);
        chkw("restart_pool", pool_o, fillp(8'h04));

        // sta with valid_i in the same cycle drops that beat
        sta = 1'b1; valid_i = 1'b1; conv_i = fill(8'h99);
        @(negedge clk) sta = 1'b0; conv_i = fill(8'h01);
        @(negedge clk) conv_i = fill(8'h02);
        chk("stavalid_dropped", 32'(valid_o), 0);
        @(negedge clk) valid_i = 1'b0;
        chk("stavalid_valid", 32'(valid_o), 1);
        chk("stavalid_row", 32'(row_o), 0);
        chkw("stavalid_pool", pool_o, fillp(8'h02));

        // reset mid-map
        valid_i = 1'b1; conv_i = fill(8'h30);
        @(negedge clk) conv_i = fill(8'h31);
        @(negedge clk) conv_i = fill(8'h32);
        @(negedge clk) valid_i = 1'b0; rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(valid_o), 0);
        chkw("midrst_pool", pool_o, '0);
        chk("midrst_row", 32'(row_o), 0);
        chk("midrst_map", 32'(map_o), 0);
        @(negedge clk) rst_n = 1'b1; valid_i = 1'b1; conv_i = fill(8'h08);
        @(negedge clk) conv_i = fill(8'h09);
        @(negedge clk) valid_i = 1'b0;
        chk("midrst_needs_sta", 32'(valid_o), 0);
        sta = 1'b1;
        @(negedge clk) sta = 1'b0; valid_i = 1'b1; conv_i = fill(8'h22);
        @(negedge clk) conv_i = fill(8'h11);
        @(negedge clk) valid_i = 1'b0;
        chk("midrst_valid2", 32'(valid_o), 1);
        chk("midrst_row2", 32'(row_o), 0);
        chk("midrst_map2", 32'(map_o), 0);
        chkw("midrst_pool2", pool_o, fillp(8'h22));

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
